// File: rtl/jtag_host_driver.sv
// JTAG host sequencer: turns TAP-reset / IR-scan / DR-scan commands into registered TMS/TDI
// streams, mirrors the target TAP state and captures TDO. Optional macro: JTAG_DRV_RTI_WAIT_EN.
module jtag_host_driver #(
  parameter int MAX_LEN    = 64,
  parameter int RTI_CYCLES = 2
) (
  input  logic               tck,
  input  logic               trstn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [6:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int         IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [6:0] MAX_LEN_L = 7'(MAX_LEN);

`ifdef JTAG_DRV_RTI_WAIT_EN
  localparam int RTI_WAIT = RTI_CYCLES;
`else
  // Extra idle cycles are disabled; RTI_CYCLES is deliberately ignored.
  localparam int RTI_WAIT = RTI_CYCLES * 0;
`endif

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } tap_state_t;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_PRE, S_SHIFT, S_POST, S_WAIT, S_ERR, S_TRST, S_RESP
  } drv_state_t;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic m);
    case (s)
      TLR:      return m ? TLR    : RTI;
      RTI:      return m ? SEL_DR : RTI;
      SEL_DR:   return m ? SEL_IR : CAP_DR;
      CAP_DR:   return m ? EX1_DR : SHIFT_DR;
      SHIFT_DR: return m ? EX1_DR : SHIFT_DR;
      EX1_DR:   return m ? UPD_DR : PAUSE_DR;
      PAUSE_DR: return m ? EX2_DR : PAUSE_DR;
      EX2_DR:   return m ? UPD_DR : SHIFT_DR;
      UPD_DR:   return m ? SEL_DR : RTI;
      SEL_IR:   return m ? TLR    : CAP_IR;
      CAP_IR:   return m ? EX1_IR : SHIFT_IR;
      SHIFT_IR: return m ? EX1_IR : SHIFT_IR;
      EX1_IR:   return m ? UPD_IR : PAUSE_IR;
      PAUSE_IR: return m ? EX2_IR : PAUSE_IR;
      EX2_IR:   return m ? UPD_IR : SHIFT_IR;
      UPD_IR:   return m ? SEL_DR : RTI;
      default:  return TLR;
    endcase
  endfunction

  drv_state_t         state_q, state_n;
  tap_state_t         tap_q;
  logic               tms_q, tms_n;
  logic               tdi_q, tdi_n;
  logic               ir_q, ir_n;
  logic               err_q, err_n;
  logic [6:0]         len_q, len_n;
  logic [6:0]         bit_q, bit_n;
  logic [7:0]         cnt_q, cnt_n;
  logic [MAX_LEN-1:0] sh_q, sh_n;
  logic [MAX_LEN-1:0] rsp_data_q;
  logic [6:0]         cap_q;
  logic               accept;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state_q;
    tms_n   = 1'b0;
    tdi_n   = 1'b0;
    ir_n    = ir_q;
    err_n   = err_q;
    len_n   = len_q;
    bit_n   = bit_q;
    cnt_n   = cnt_q;
    sh_n    = sh_q;
    accept  = 1'b0;

    case (state_q)
      S_INIT: if (!tms_q) state_n = S_IDLE;

      S_IDLE: if (cmd_valid) begin
        accept = 1'b1;
        len_n  = cmd_len;
        sh_n   = cmd_data;
        ir_n   = (cmd_type == 2'd1);
        err_n  = 1'b0;
        cnt_n  = '0;
        bit_n  = '0;
        if (cmd_type == 2'd3 || cmd_len == 7'd0 || cmd_len > MAX_LEN_L) begin
          err_n   = 1'b1;
          state_n = S_ERR;
        end else begin
          tms_n   = 1'b1;
          state_n = (cmd_type == 2'd0) ? S_TRST : S_PRE;
        end
      end

      // Prefix after the leading 1: IR continues 1,0,0 and DR continues 0,0.
      S_PRE: begin
        cnt_n = cnt_q + 8'd1;
        if (cnt_q == (ir_q ? 8'd3 : 8'd2)) begin
          state_n = S_SHIFT;
          tdi_n   = sh_q[0];
          sh_n    = sh_q >> 1;
          tms_n   = (len_q == 7'd1);
        end else begin
          tms_n = ir_q && (cnt_q == 8'd0);
        end
      end

      S_SHIFT: begin
        if (bit_q == len_q - 7'd1) begin
          state_n = S_POST;
          tms_n   = 1'b1;
          cnt_n   = '0;
        end else begin
          bit_n = bit_q + 7'd1;
          tdi_n = sh_q[0];
          sh_n  = sh_q >> 1;
          tms_n = (bit_q + 7'd2 == len_q);
        end
      end

      S_POST: begin
        cnt_n = cnt_q + 8'd1;
        if (cnt_q != 8'd0) begin
          cnt_n   = '0;
          state_n = (RTI_WAIT > 0) ? S_WAIT : S_RESP;
        end
      end

      S_WAIT: begin
        cnt_n = cnt_q + 8'd1;
        if (cnt_q == 8'(RTI_WAIT - 1)) state_n = S_RESP;
      end

      S_ERR: state_n = S_RESP;

      // Five ones reach Test-Logic-Reset from anywhere, then a zero lands in Run-Test/Idle.
      S_TRST: begin
        cnt_n = cnt_q + 8'd1;
        tms_n = (cnt_q < 8'd4);
        if (cnt_q == 8'd5) state_n = S_RESP;
      end

      S_RESP: if (rsp_ready) state_n = S_IDLE;

      default: state_n = S_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      state_q <= S_INIT;
      tap_q   <= TLR;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      ir_q    <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_n;
      tap_q   <= tap_next(tap_q, tms_q);
      tms_q   <= tms_n;
      tdi_q   <= tdi_n;
      ir_q    <= ir_n;
      err_q   <= err_n;
      len_q   <= len_n;
      bit_q   <= bit_n;
      cnt_q   <= cnt_n;
      sh_q    <= sh_n;
    end
  end

  // TDO is taken on exactly the edges where the target itself shifts.
  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      rsp_data_q <= '0;
      cap_q      <= '0;
    end else if (accept) begin
      rsp_data_q <= '0;
      cap_q      <= '0;
    end else if (tap_q == SHIFT_IR || tap_q == SHIFT_DR) begin
      rsp_data_q[cap_q[IW-1:0]] <= tdo;
      cap_q                     <= cap_q + 7'd1;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = err_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_host_driver.sv
// Randomized scoreboard bench for jtag_host_driver with a behavioural target TAP
// (IDCODE, ADDR and BYPASS data registers) and a chain-level reference model.
`timescale 1ns/1ps
module tb_jtag_host_driver;

  localparam int MAX_LEN    = 64;
  localparam int RTI_CYCLES = 2;
`ifdef JTAG_DRV_RTI_WAIT_EN
  localparam int EXTRA = RTI_CYCLES;
`else
  localparam int EXTRA = 0;
`endif

  localparam logic [3:0]  OP_IDCODE  = 4'h1;
  localparam logic [3:0]  OP_ADDR    = 4'h2;
  localparam logic [3:0]  OP_BYPASS  = 4'hF;
  localparam logic [3:0]  IR_CAPTURE = 4'b0101;
  localparam logic [31:0] IDCODE_VAL = 32'h0000010F;

  localparam int T_TLR = 0, T_RTI = 1, T_SELDR = 2, T_CAPDR = 3, T_SHDR = 4, T_EX1DR = 5,
                 T_PDR = 6, T_EX2DR = 7, T_UPDDR = 8, T_SELIR = 9, T_CAPIR = 10, T_SHIR = 11,
                 T_EX1IR = 12, T_PIR = 13, T_EX2IR = 14, T_UPDIR = 15;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic        tck = 1'b0;
  logic        trstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = '0;
  logic [6:0]  cmd_len = '0;
  logic [63:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic        tms;
  logic        tdi;
  logic        tdo = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  jtag_host_driver #(.MAX_LEN(MAX_LEN), .RTI_CYCLES(RTI_CYCLES)) dut (
    .tck(tck), .trstn(trstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 tck = ~tck;
  always @(posedge tck) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- target TAP (environment) ----------------
  int          nxt[16][2];
  int          t_state;
  logic [3:0]  t_ir;
  logic [3:0]  ir_sr;
  logic [31:0] dr_sr;
  int          dr_w;
  logic [31:0] t_addr = '0;

  initial begin
    nxt[T_TLR]   = '{T_RTI,   T_TLR};   nxt[T_RTI]   = '{T_RTI,   T_SELDR};
    nxt[T_SELDR] = '{T_CAPDR, T_SELIR}; nxt[T_CAPDR] = '{T_SHDR,  T_EX1DR};
    nxt[T_SHDR]  = '{T_SHDR,  T_EX1DR}; nxt[T_EX1DR] = '{T_PDR,   T_UPDDR};
    nxt[T_PDR]   = '{T_PDR,   T_EX2DR}; nxt[T_EX2DR] = '{T_SHDR,  T_UPDDR};
    nxt[T_UPDDR] = '{T_RTI,   T_SELDR}; nxt[T_SELIR] = '{T_CAPIR, T_TLR};
    nxt[T_CAPIR] = '{T_SHIR,  T_EX1IR}; nxt[T_SHIR]  = '{T_SHIR,  T_EX1IR};
    nxt[T_EX1IR] = '{T_PIR,   T_UPDIR}; nxt[T_PIR]   = '{T_PIR,   T_EX2IR};
    nxt[T_EX2IR] = '{T_SHIR,  T_UPDIR}; nxt[T_UPDIR] = '{T_RTI,   T_SELDR};
  end

  always @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      t_state <= T_TLR;
      t_ir    <= OP_IDCODE;
      ir_sr   <= '0;
      dr_sr   <= '0;
      dr_w    <= 1;
    end else begin
      case (t_state)
        T_TLR:   t_ir <= OP_IDCODE;
        T_CAPIR: ir_sr <= IR_CAPTURE;
        T_SHIR:  ir_sr <= {tdi, ir_sr[3:1]};
        T_UPDIR: t_ir <= ir_sr;
        T_CAPDR: begin
          dr_w  <= (t_ir == OP_IDCODE || t_ir == OP_ADDR) ? 32 : 1;
          dr_sr <= (t_ir == OP_IDCODE) ? IDCODE_VAL : (t_ir == OP_ADDR) ? t_addr : 32'd0;
        end
        T_SHDR:  dr_sr <= (dr_w == 32) ? {tdi, dr_sr[31:1]} : {31'd0, tdi};
        T_UPDDR: if (t_ir == OP_ADDR) t_addr <= dr_sr;
        default: ;
      endcase
      t_state <= nxt[t_state][tms];
    end
  end

  always @(negedge tck)
    tdo <= (t_state == T_SHIR) ? ir_sr[0] : (t_state == T_SHDR) ? dr_sr[0] : 1'b0;

  // ---------------- reference model: whole-scan chain arithmetic ----------------
  logic [3:0]  m_ir = OP_IDCODE;
  logic [31:0] m_addr = '0;

  function automatic logic [127:0] chain(input logic [63:0] d, input int w, input logic [31:0] cap);
    logic [31:0] cmask;
    cmask = 32'((64'd1 << w) - 64'd1);
    return (128'(d) << w) | 128'(cap & cmask);
  endfunction

  task automatic predict(input logic [1:0] t, input logic [6:0] l, input logic [63:0] d,
                         output exp_t e);
    int           n;
    int           w;
    logic [31:0]  cap;
    logic [127:0] ch;
    logic [63:0]  m;
    n     = int'(l);
    e.err = 1'b0;
    e.data = '0;
    e.lat = 0;
    e.acc = 0;
    if (t == 2'd3 || n == 0 || n > MAX_LEN) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (t == 2'd0) begin
      e.lat = 6;
      m_ir  = OP_IDCODE;
    end else begin
      m = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
      if (t == 2'd1) begin
        ch    = chain(d, 4, 32'(IR_CAPTURE));
        m_ir  = ch[n +: 4];
        e.lat = 4 + n + 2 + EXTRA;
      end else begin
        w   = (m_ir == OP_IDCODE || m_ir == OP_ADDR) ? 32 : 1;
        cap = (m_ir == OP_IDCODE) ? IDCODE_VAL : (m_ir == OP_ADDR) ? m_addr : 32'd0;
        ch  = chain(d, w, cap);
        if (m_ir == OP_ADDR) m_addr = ch[n +: 32];
        e.lat = 3 + n + 2 + EXTRA;
      end
      e.data = ch[63:0] & m;
    end
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;
  bit   seen = 1'b0;
  bit   hs = 1'b0;

  always @(negedge tck) begin
    if (!trstn) begin
      seen      = 1'b0;
      hs        = 1'b0;
      rsp_ready = 1'b0;
    end else begin
      if (hs) seen = 1'b0;
      if (rsp_valid && !seen) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_data", rsp_data, mon_e.data);
          check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
          check("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
          check("target_rti_at_rsp", 64'(t_state), 64'(T_RTI));
          check("cmd_ready_in_resp", 64'(cmd_ready), 64'd0);
        end
      end
      if (rsp_valid) check("resp_tms", 64'(tms), 64'd0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      hs = rsp_valid && rsp_ready;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [1:0] t, input logic [6:0] l, input logic [63:0] d,
                      input bit expect_rsp);
    exp_t e;
    int   w;
    @(negedge tck);
    cmd_type  = t;
    cmd_len   = l;
    cmd_data  = d;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 2000) begin
      @(negedge tck);
      w++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    if (expect_rsp) begin
      predict(t, l, d, e);
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge tck);
    cmd_valid = 1'b0;
    cmd_type  = 2'($urandom);
    cmd_len   = 7'($urandom);
    cmd_data  = {$urandom, $urandom};
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((sb.size() != 0 || !cmd_ready) && w < 5000) begin
      @(negedge tck);
      w++;
    end
    if (sb.size() != 0 || !cmd_ready) check("idle_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int          tseq[6];
    logic [3:0]  ops[4];
    logic [63:0] d;
    int          r;
    tseq = '{1, 1, 1, 1, 1, 0};
    ops  = '{OP_IDCODE, OP_ADDR, OP_BYPASS, 4'h7};

    // Reset state and INIT sequence
    repeat (3) @(negedge tck);
    check("rst_tms", 64'(tms), 64'd1);
    check("rst_tdi", 64'(tdi), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    trstn = 1'b1;
    @(negedge tck);
    check("init_tms", 64'(tms), 64'd0);
    check("init_cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge tck);
    check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    check("idle_target_rti", 64'(t_state), 64'(T_RTI));

    // TAP reset command
    send(2'd0, 7'd1, 64'd0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      check("trst_tms_seq", 64'(tms), 64'(tseq[i]));
      if (i < 5) @(negedge tck);
    end
    wait_idle();

    // IDCODE read
    send(2'd1, 7'd4, 64'(OP_IDCODE), 1'b1);
    send(2'd2, 7'd32, 64'd0, 1'b1);
    wait_idle();

    // Address register write then read-back
    send(2'd1, 7'd4, 64'(OP_ADDR), 1'b1);
    send(2'd2, 7'd32, 64'hDEADBEEF, 1'b1);
    wait_idle();
    check("target_addr", 64'(t_addr), 64'hDEADBEEF);
    send(2'd2, 7'd32, 64'h12345678, 1'b1);
    wait_idle();

    // Illegal commands: no TMS activity, error one cycle after accept
    send(2'd3, 7'd8, 64'hFF, 1'b1);
    check("err_type_tms", 64'(tms), 64'd0);
    wait_idle();
    send(2'd1, 7'd0, 64'hFF, 1'b1);
    check("err_len0_tms", 64'(tms), 64'd0);
    wait_idle();
    send(2'd2, 7'd65, 64'hFF, 1'b1);
    check("err_len65_tms", 64'(tms), 64'd0);
    check("err_target_rti", 64'(t_state), 64'(T_RTI));
    wait_idle();

    // trstn during bit 10 of a 32-bit IDCODE DR scan
    send(2'd1, 7'd4, 64'(OP_IDCODE), 1'b1);
    send(2'd2, 7'd32, {$urandom, $urandom}, 1'b0);
    repeat (12) @(negedge tck);
    trstn = 1'b0;
    #1;
    check("abort_tms", 64'(tms), 64'd1);
    check("abort_tdi", 64'(tdi), 64'd0);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_cmd_ready", 64'(cmd_ready), 64'd0);
    check("abort_rsp_data", rsp_data, 64'd0);
    m_ir = OP_IDCODE;
    repeat (6) @(negedge tck);
    trstn = 1'b1;
    wait_idle();
    send(2'd1, 7'd4, 64'(OP_IDCODE), 1'b1);
    send(2'd2, 7'd32, 64'd0, 1'b1);
    wait_idle();

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      d = {$urandom, $urandom};
      if (r == 0) begin
        send(2'd0, 7'($urandom_range(1, 64)), d, 1'b1);
      end else if (r == 1) begin
        case ($urandom_range(0, 2))
          0:       send(2'd3, 7'($urandom_range(1, 64)), d, 1'b1);
          1:       send(2'($urandom_range(1, 2)), 7'd0, d, 1'b1);
          default: send(2'($urandom_range(1, 2)), 7'($urandom_range(65, 127)), d, 1'b1);
        endcase
      end else if (r <= 4) begin
        if ($urandom_range(0, 3) != 0)
          send(2'd1, 7'd4, 64'(ops[$urandom_range(0, 3)]), 1'b1);
        else
          send(2'd1, 7'($urandom_range(1, 10)), d, 1'b1);
      end else begin
        send(2'd2, 7'($urandom_range(1, 64)), d, 1'b1);
      end
    end
    wait_idle();
    check("final_addr_model", 64'(t_addr), 64'(m_addr));
    repeat (3) @(negedge tck);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
